// File: rtl/pipeline_stage_sequencer_pkg.sv
// Shared defaults and sizing helpers for the pipeline stage sequencer.
package pipeline_stage_sequencer_pkg;

    localparam int DEFAULT_N_STAGES         = 5;
    localparam int DEFAULT_STATE_VARS_WIDTH = 8;

    // Wide enough to hold every count from 0 to n_stages inclusive.
    function automatic int occ_width(input int n_stages);
        return $clog2(n_stages + 1);
    endfunction

endpackage

// File: rtl/pipeline_stage_slot.sv
// One stage register: flush > load > vacate-clear > write-back > hold.
// Latency 1; no backpressure of its own, the parent decides load/vacate.
module pipeline_stage_slot
    import pipeline_stage_sequencer_pkg::*;
#(
    parameter int W = DEFAULT_STATE_VARS_WIDTH
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic [W-1:0] i_load_vars,
    input  logic         i_vacate,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    output logic         o_valid,
    output logic [W-1:0] o_vars
);

    logic         r_valid;
    logic [W-1:0] r_vars;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_vars  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_vars  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_vars  <= i_load_vars;
        end else if (i_vacate) begin
            r_valid <= 1'b0;
            r_vars  <= '0;
        end else if (r_valid && i_wr_en) begin
            // Write-back only lands on a live entry; empty slots stay zero.
            r_vars  <= i_wr_data;
        end
    end

    assign o_valid = r_valid;
    assign o_vars  = r_vars;

endmodule

// File: rtl/pipeline_stage_sequencer.sv
// Bubble-free chain of N stage slots; entry reaches stage 0 one edge after accept.
// A stage advances only when the next one is empty or vacating; in_ready drops when stage 0 is stuck or on flush.
module pipeline_stage_sequencer
    import pipeline_stage_sequencer_pkg::*;
#(
    parameter int N_STAGES         = DEFAULT_N_STAGES,
    parameter int STATE_VARS_WIDTH = DEFAULT_STATE_VARS_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [STATE_VARS_WIDTH-1:0]            in_vars,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_STAGES-1:0]                    stage_done,
    input  logic [N_STAGES-1:0]                    stage_wr_en,
    input  logic [N_STAGES*STATE_VARS_WIDTH-1:0]   stage_wr_data,
    output logic [N_STAGES*STATE_VARS_WIDTH-1:0]   stage_vars,
    output logic [N_STAGES-1:0]                    stage_valid,
    output logic [STATE_VARS_WIDTH-1:0]            out_vars,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [occ_width(N_STAGES)-1:0]         occupancy
);

    localparam int W     = STATE_VARS_WIDTH;
    localparam int OCC_W = occ_width(N_STAGES);

    logic [N_STAGES-1:0]   w_valid;
    logic [N_STAGES-1:0]   w_adv;
    logic [N_STAGES-1:0]   w_load;
    logic [N_STAGES*W-1:0] w_vars;
    logic [N_STAGES*W-1:0] w_load_vars;
    logic                  w_accept;
    logic [OCC_W-1:0]      r_occupancy;

    // Evaluated tail-first so a full pipeline with all done bits set moves as one.
    always_comb begin
        w_adv = '0;
        w_adv[N_STAGES-1] = w_valid[N_STAGES-1] & stage_done[N_STAGES-1] & out_ready;
        for (int i = N_STAGES - 2; i >= 0; i--) begin
            w_adv[i] = w_valid[i] & stage_done[i] & (~w_valid[i+1] | w_adv[i+1]);
        end
    end

    assign in_ready = (~w_valid[0] | w_adv[0]) & ~flush;
    assign w_accept = in_valid & in_ready;

    // A write-back issued in the same cycle as an advance rides along to the next slot.
    always_comb begin
        w_load      = '0;
        w_load_vars = '0;
        w_load[0]          = w_accept;
        w_load_vars[0+:W]  = in_vars;
        for (int i = 1; i < N_STAGES; i++) begin
            w_load[i]          = w_adv[i-1];
            w_load_vars[i*W+:W] = stage_wr_en[i-1] ? stage_wr_data[(i-1)*W+:W]
                                                   : w_vars[(i-1)*W+:W];
        end
    end

    for (genvar g = 0; g < N_STAGES; g++) begin : g_slot
        pipeline_stage_slot #(.W(W)) u_slot (
            .clk         (clk),
            .i_rst_n     (rst),
            .i_flush     (flush),
            .i_load      (w_load[g]),
            .i_load_vars (w_load_vars[g*W+:W]),
            .i_vacate    (w_adv[g]),
            .i_wr_en     (stage_wr_en[g]),
            .i_wr_data   (stage_wr_data[g*W+:W]),
            .o_valid     (w_valid[g]),
            .o_vars      (w_vars[g*W+:W])
        );
    end

    // Internal advances never change the count; only accept and drain do.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occupancy <= '0;
        end else if (flush) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= r_occupancy + OCC_W'(w_accept) - OCC_W'(w_adv[N_STAGES-1]);
        end
    end

    assign stage_valid = w_valid;
    assign stage_vars  = w_vars;
    assign out_vars    = w_vars[(N_STAGES-1)*W+:W];
    assign out_valid   = w_valid[N_STAGES-1] & stage_done[N_STAGES-1];
    assign occupancy   = r_occupancy;

endmodule
